// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin pick helper for the sprite/background ROM arbiter.
package rom_arb_pkg;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 4;
  localparam int MAX_REQ    = 8;

  typedef logic [MAX_REQ-1:0] tag_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req_mask scanning ptr, ptr+1, ... modulo n.
  // Walks offsets high to low so the smallest offset is the last writer.
  function automatic pick_t rr_pick(input tag_t req_mask, input logic [2:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j -= n;
        if (req_mask[3'(j)]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Requester/ROM bus of the arbiter; slave is the arbiter side, master the environment.
interface rom_fetch_arbiter_if import rom_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [DATA_W-1:0]         rd_data;
  logic [NUM_REQ-1:0]        rd_valid;
  logic                      busy;

  modport master (output req, req_addr, rom_q,
                  input  gnt, rom_address, rd_data, rd_valid, busy);
  modport slave  (input  req, req_addr, rom_q,
                  output gnt, rom_address, rd_data, rd_valid, busy);
endinterface

// File: rtl/rom_arb_tag_pipe.sv
// ROM_LAT-deep shift register of one-hot grant tags; the last stage is rd_valid.
module rom_arb_tag_pipe import rom_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ROM_LAT = 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rd_valid,
  output logic               load_en,
  output logic               pending
);
  logic [ROM_LAT-1:0][NUM_REQ-1:0] tag_pipe;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // rom_q is captured on the edge where a tag moves into the last stage.
  generate
    if (ROM_LAT == 1) begin : g_lat1
      assign load_en = |gnt;
    end else begin : g_latn
      assign load_en = |tag_pipe[ROM_LAT-2];
    end
  endgenerate

  assign rd_valid = tag_pipe[ROM_LAT-1];
  assign pending  = |tag_pipe;
endmodule

// File: rtl/rom_fetch_arbiter.sv
// Registered round-robin arbiter sharing one single-port ROM among NUM_REQ requesters.
// ROM_ARB_DISPLAY_PRIO_EN: requester 0 gets fixed top priority over the round robin.
module rom_fetch_arbiter import rom_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic vga_clk,
  input  logic reset,
  rom_fetch_arbiter_if.slave bus
);
  logic [2:0]         ptr;
  logic [NUM_REQ-1:0] gnt_q, gnt_n, rd_valid;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  data_q;
  logic               load_en, pending, ptr_upd;
  tag_t               elig;
  pick_t              pick;

  always_comb begin
    pick    = '0;
    ptr_upd = 1'b0;
    elig    = '0;
    elig[NUM_REQ-1:0] = bus.req & ~gnt_q;
`ifdef ROM_ARB_DISPLAY_PRIO_EN
    // Display wins outright and leaves the pointer alone for the others.
    if (elig[0]) begin
      pick.found = 1'b1;
      pick.idx   = 3'd0;
    end else begin
      pick    = rr_pick(elig & ~tag_t'(1), ptr, NUM_REQ);
      ptr_upd = pick.found;
    end
`else
    pick    = rr_pick(elig, ptr, NUM_REQ);
    ptr_upd = pick.found;
`endif
    gnt_n  = '0;
    addr_n = addr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.found && pick.idx == 3'(i)) begin
        gnt_n[i] = 1'b1;
        addr_n   = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= '0;
      addr_q <= '0;
      ptr    <= '0;
    end else begin
      gnt_q  <= gnt_n;
      addr_q <= addr_n;
      if (ptr_upd) ptr <= (pick.idx == 3'(NUM_REQ-1)) ? 3'd0 : pick.idx + 3'd1;
    end
  end

  rom_arb_tag_pipe #(.NUM_REQ(NUM_REQ), .ROM_LAT(ROM_LAT)) u_tag_pipe (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .gnt      (gnt_q),
    .rd_valid (rd_valid),
    .load_en  (load_en),
    .pending  (pending)
  );

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)        data_q <= '0;
    else if (load_en) data_q <= bus.rom_q;
  end

  assign bus.gnt         = gnt_q;
  assign bus.rom_address = addr_q;
  assign bus.rd_data     = data_q;
  assign bus.rd_valid    = rd_valid;
  assign bus.busy        = (|gnt_q) | pending;
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench: ROM_LAT=1 arbiter (negedge ROM model) and ROM_LAT=3 arbiter (pipelined ROM model).
module tb_rom_fetch_arbiter;
  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rom_fetch_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  rom_fetch_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  rom_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut_a (
    .vga_clk (clk), .reset (rst), .bus (ifa.slave));
  rom_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut_b (
    .vga_clk (clk), .reset (rst), .bus (ifb.slave));

  // ROM contents: low nibble of a ^ a>>4 ^ a>>8
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 4) ^ (a >> 8));
  endfunction

  always @(negedge clk) ifa.rom_q <= rom_fn(ifa.rom_address);

  logic [DW-1:0] pb1, pb2;
  always @(posedge clk) begin
    pb1 <= rom_fn(ifb.rom_address);
    pb2 <= pb1;
  end
  assign ifb.rom_q = pb2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g [5];
  logic [3:0] exp_d [5];
  logic [3:0] wrap_g [2];
  logic [2:0] wrap_ptr;

  initial begin
`ifdef ROM_ARB_DISPLAY_PRIO_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
    exp_d = '{4'h1, 4'h2, 4'h1, 4'h5, 4'h1};
    wrap_g = '{4'b0001, 4'b1000};
    wrap_ptr = 3'd0;
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{4'h1, 4'h2, 4'h5, 4'h7, 4'h1};
    wrap_g = '{4'b1000, 4'b0001};
    wrap_ptr = 3'd1;
`endif
    rst = 1'b1;
    ifa.req = '0;
    ifa.req_addr = {17'h00700, 17'h00140, 17'h00020, 17'h00001};
    ifb.req = '0;
    ifb.req_addr = {17'h0, 17'h0, 17'h00700, 17'h0};
    tick(); tick();
    ifa.req = 4'b1111;
    tick();
    check("rst_gnt", ifa.gnt, 4'b0000);
    check("rst_addr", ifa.rom_address, 17'h0);
    check("rst_rd_data", ifa.rd_data, 4'h0);
    check("rst_rd_valid", ifa.rd_valid, 4'b0000);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_busy_b", ifb.busy, 1'b0);
    rst = 1'b0;

    // all four requesting
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("rr_gnt%0d", s), ifa.gnt, exp_g[s]);
      check($sformatf("rr_rv%0d", s), ifa.rd_valid, (s == 0) ? 4'b0000 : exp_g[s-1]);
      if (s > 0) check($sformatf("rr_data%0d", s), ifa.rd_data, exp_d[s-1]);
      check($sformatf("rr_busy%0d", s), ifa.busy, 1'b1);
    end
    ifa.req = '0;
    tick();
    check("drain_gnt", ifa.gnt, 4'b0000);
    check("drain_rv", ifa.rd_valid, 4'b0001);
    check("drain_data", ifa.rd_data, 4'h1);
    tick();
    check("idle_rv", ifa.rd_valid, 4'b0000);
    check("idle_busy", ifa.busy, 1'b0);

    // single requester masked every other cycle
    ifa.req = 4'b0100;
    for (int s = 0; s < 4; s++) begin
      tick();
      check($sformatf("one_gnt%0d", s), ifa.gnt, (s % 2 == 0) ? 4'b0100 : 4'b0000);
      check($sformatf("one_rv%0d", s), ifa.rd_valid, (s % 2 == 1) ? 4'b0100 : 4'b0000);
      if (s % 2 == 1) check($sformatf("one_data%0d", s), ifa.rd_data, 4'h5);
    end
    check("one_addr", ifa.rom_address, 17'h00140);

    // wrap-around from ptr=3
    ifa.req = 4'b1001;
    tick();
    check("wrap_gnt0", ifa.gnt, wrap_g[0]);
    tick();
    check("wrap_gnt1", ifa.gnt, wrap_g[1]);
    check("wrap_ptr", dut_a.ptr, wrap_ptr);
    ifa.req = '0;
    tick(); tick();

`ifdef ROM_ARB_DISPLAY_PRIO_EN
    ifa.req = 4'b0111;
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("prio_gnt%0d", s), ifa.gnt, exp_g[s]);
    end
    ifa.req = '0;
    tick(); tick();
`endif

    // ROM_LAT=3 single grant
    ifb.req = 4'b0010;
    tick();
    ifb.req = '0;
    check("lat3_gnt_k", ifb.gnt, 4'b0010);
    check("lat3_addr_k", ifb.rom_address, 17'h00700);
    check("lat3_busy_k", ifb.busy, 1'b1);
    check("lat3_rv_k", ifb.rd_valid, 4'b0000);
    tick();
    check("lat3_gnt_k1", ifb.gnt, 4'b0000);
    check("lat3_busy_k1", ifb.busy, 1'b1);
    check("lat3_rv_k1", ifb.rd_valid, 4'b0000);
    tick();
    check("lat3_busy_k2", ifb.busy, 1'b1);
    check("lat3_rv_k2", ifb.rd_valid, 4'b0000);
    tick();
    check("lat3_rv_k3", ifb.rd_valid, 4'b0010);
    check("lat3_data_k3", ifb.rd_data, 4'h7);
    check("lat3_busy_k3", ifb.busy, 1'b1);
    tick();
    check("lat3_rv_k4", ifb.rd_valid, 4'b0000);
    check("lat3_busy_k4", ifb.busy, 1'b0);

    // reset in the cycle after a grant
    ifa.req = 4'b0001;
    tick();
    check("mid_gnt", ifa.gnt, 4'b0001);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", ifa.gnt, 4'b0000);
    check("mid_rst_addr", ifa.rom_address, 17'h0);
    check("mid_rst_busy", ifa.busy, 1'b0);
    check("mid_rst_rv", ifa.rd_valid, 4'b0000);
    check("mid_rst_data", ifa.rd_data, 4'h0);
    ifa.req = '0;
    tick();
    check("mid_hold_rv", ifa.rd_valid, 4'b0000);
    rst = 1'b0;
    tick();
    check("mid_post_rv0", ifa.rd_valid, 4'b0000);
    check("mid_post_busy", ifa.busy, 1'b0);
    tick();
    check("mid_post_rv1", ifa.rd_valid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares one single-port sprite/background ROM (palettized, 4-bit index) between NUM_REQ requesters: display scanout, jet sprites, bullets, etc.
- Registered round-robin arbiter. Drives the ROM address and returns ROM data tagged to the requester that was granted.
- Sits between the sprite/background pixel generators and the ROM instance, in the vga_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 17, ROM address width.
- DATA_W, 4, ROM word width (palette index).
- ROM_LAT, 1, vga_clk cycles from rom_address change to rom_q valid for sampling (1..3).

Ports:
- vga_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, registered
- rom_address  out  ADDR_W  to ROM, registered
- rom_q  in  DATA_W  from ROM
- rd_data  out  DATA_W  returned ROM word, registered
- rd_valid  out  NUM_REQ  one-hot, rd_data belongs to requester i
- busy  out  1  any grant or read in flight

Behaviour:
- Reset (async assert, sync release): gnt=0, rom_address=0, rd_data=0, rd_valid=0, busy=0, rr pointer=0, tag pipeline cleared.
- Eligibility: req[i] is eligible when req[i]=1 and gnt[i]=0. A requester whose grant is currently showing is masked.
- Arbitration: each posedge, the winner is the first eligible index scanning ptr, ptr+1, ... modulo NUM_REQ.
  - On a win: gnt <= onehot(winner), rom_address <= req_addr[winner], ptr <= (winner+1) mod NUM_REQ.
  - No eligible requester: gnt <= 0, rom_address holds its value, ptr holds its value.
- Handshake:
  - Requester holds req and req_addr stable until it sees gnt[i]=1, then may drop req or present a new address.
  - The masking rule means one requester gets at most one grant every 2 cycles.
  - Different requesters can be granted back-to-back, one grant per cycle at full throughput.
- Latency:
  - gnt[i] high in cycle k; rom_address valid in cycle k.
  - rom_q is sampled at the end of cycle k+ROM_LAT-1.
  - rd_valid[i]=1 and rd_data valid in cycle k+ROM_LAT, for exactly one cycle.
  - ROM_LAT=1 covers a negedge-clocked ROM.
- Tag pipeline: ROM_LAT stages of one-hot tags. It shifts every cycle, entry = gnt, and the last stage drives rd_valid.
  - rd_data is loaded only when the last tag is nonzero, otherwise it holds.
- busy = |gnt OR any tag stage nonzero.
- All req low: no grants; in-flight reads still complete.
- Wrap-around: ptr=NUM_REQ-1 with winner NUM_REQ-1 gives ptr 0.
- Reset mid-operation: in-flight tags are discarded and no rd_valid appears after release.
- Out-of-range or X req_addr is passed through unchecked.

Optional Feature:
- Macro ROM_ARB_DISPLAY_PRIO_EN.
- Defined: requester 0 (display scanout) has fixed top priority. If eligible it always wins, and ptr is not updated on its win. The remaining requesters round-robin among themselves when requester 0 is not eligible.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

Decomposition:
- Package rom_arb_pkg holds:
  - localparam default widths (ADDR_W=17, DATA_W=4);
  - function rr_pick(req_mask, ptr), returning winner index and a found bit;
  - typedef for a tag vector.
- One sub-module, rom_arb_tag_pipe: ROM_LAT-deep shift register of one-hot tags with reset. It outputs rd_valid and its load enable.

Test Plan:
- Reset with req=4'b1111: after release, gnt sequence 0001, 0010, 0100, 1000, 0001; rd_valid repeats the same sequence 1 cycle later (ROM_LAT=1).
- Single requester req=4'b0100 held high, addr 0x00140: gnt[2] pulses every other cycle; rd_data equals the model ROM[0x00140] with rd_valid[2] one cycle after each grant.
- Wrap: ptr=3 with req=4'b1001 → gnt=1000, then 0001; ptr ends at 1.
- ROM_LAT=3, single grant to req1 at cycle k → rd_valid=0010 exactly at cycle k+3; busy high in cycles k..k+3, low at k+4.
- Reset asserted the cycle after a grant → no rd_valid pulse, all outputs 0 immediately (asynchronous).
- With ROM_ARB_DISPLAY_PRIO_EN and req=4'b0111, req0 re-raised every other cycle: req0 wins every cycle it is eligible; req1 and req2 alternate in the gaps.
